// File: rtl/rgb_to_hsv.sv
// rgb_to_hsv: iterative RGB to HSV converter with valid/ready handshakes on both sides.
// One restoring divider is reused for saturation and then hue; fixed 35-cycle latency.
module rgb_to_hsv #(
    parameter int  HUE_STEPS = 360,
    localparam int HW        = $clog2(HUE_STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    r,
    input  logic [7:0]    g,
    input  logic [7:0]    b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [HW-1:0] h,
    output logic [7:0]    s,
    output logic [7:0]    v
);
    localparam int HS6 = HUE_STEPS / 6;

    typedef enum logic [2:0] {IDLE, PREP, DIV_S, DIV_H, FIX, DONE} state_t;

    state_t             r_state, w_next;
    logic [7:0]         r_r, r_g, r_b;
    logic [7:0]         r_max, r_delta, r_mag, r_dvs, r_rem, r_sq, r_hq;
    logic signed [10:0] r_base, r_hsgn;
    logic               r_neg, r_fix;
    logic [3:0]         r_cnt;
    logic [15:0]        r_quo;

    logic               w_rmax, w_gmax, w_ge, w_zero;
    logic [7:0]         w_max, w_min, w_delta, w_mag, w_rem_n;
    logic signed [10:0] w_num, w_base;
    logic [8:0]         w_rem_sh;
    logic [15:0]        w_quo_n;

    assign in_ready = r_state == IDLE;
    assign w_zero   = r_delta == 8'd0;

    // Sector priority on ties is r, then g, then b.
    assign w_rmax  = r_r >= r_g && r_r >= r_b;
    assign w_gmax  = !w_rmax && r_g >= r_b;
    assign w_max   = w_rmax ? r_r : w_gmax ? r_g : r_b;
    assign w_min   = (r_r <= r_g && r_r <= r_b) ? r_r : (r_g <= r_b) ? r_g : r_b;
    assign w_delta = w_max - w_min;
    assign w_num   = w_rmax ? $signed({3'b0, r_g}) - $signed({3'b0, r_b})
                   : w_gmax ? $signed({3'b0, r_b}) - $signed({3'b0, r_r})
                   :          $signed({3'b0, r_r}) - $signed({3'b0, r_g});
    assign w_base  = w_rmax ? 11'sd0 : w_gmax ? 11'(HUE_STEPS / 3) : 11'(2 * HUE_STEPS / 3);
    assign w_mag   = 8'(w_num[10] ? -w_num : w_num);

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign w_rem_sh = {r_rem, r_quo[15]};
    assign w_ge     = w_rem_sh >= {1'b0, r_dvs};
    assign w_rem_n  = w_ge ? 8'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[7:0];
    assign w_quo_n  = {r_quo[14:0], w_ge};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = in_valid ? PREP : IDLE;
            PREP:    w_next = DIV_S;
            DIV_S:   w_next = r_cnt == 4'd15 ? DIV_H : DIV_S;
            DIV_H:   w_next = r_cnt == 4'd15 ? FIX : DIV_H;
            FIX:     w_next = r_fix ? DONE : FIX;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_max     <= '0;
            r_delta   <= '0;
            r_mag     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_sq      <= '0;
            r_hq      <= '0;
            r_base    <= '0;
            r_hsgn    <= '0;
            r_neg     <= 1'b0;
            r_fix     <= 1'b0;
            r_cnt     <= '0;
            h         <= '0;
            s         <= '0;
            v         <= '0;
            out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: if (in_valid) begin
                    r_r <= r;
                    r_g <= g;
                    r_b <= b;
                end
                PREP: begin
                    r_max   <= w_max;
                    r_delta <= w_delta;
                    r_base  <= w_base;
                    r_neg   <= w_num[10];
                    r_mag   <= w_mag;
                    r_rem   <= '0;
                    r_quo   <= {8'b0, w_delta} * 16'd255;
                    r_dvs   <= w_max;
                    r_cnt   <= '0;
                end
                DIV_S: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_sq  <= w_zero ? 8'd0 : w_quo_n[7:0];
                        r_rem <= '0;
                        r_quo <= 16'(HS6) * {8'b0, r_mag};
                        r_dvs <= r_delta;
                    end else begin
                        r_rem <= w_rem_n;
                        r_quo <= w_quo_n;
                    end
                end
                DIV_H: begin
                    r_cnt <= r_cnt + 4'd1;
                    r_rem <= w_rem_n;
                    r_quo <= w_quo_n;
                    if (r_cnt == 4'd15)
                        r_hq <= w_zero ? 8'd0 : w_quo_n[7:0];
                end
                FIX: begin
                    r_fix <= !r_fix;
                    if (!r_fix)
                        r_hsgn <= r_neg ? r_base - $signed({3'b0, r_hq}) : r_base + $signed({3'b0, r_hq});
                    else begin
                        h         <= HW'(r_hsgn[10] ? r_hsgn + 11'(HUE_STEPS) : r_hsgn);
                        s         <= r_sq;
                        v         <= r_max;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_to_hsv.sv
// tb_rgb_to_hsv: directed checks of rgb_to_hsv results, latency, backpressure and reset.
module tb_rgb_to_hsv;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] r = '0, g = '0, b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] h;
    logic [7:0] s, v;

    int checks = 0;
    int errors = 0;

    rgb_to_hsv dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .h(h), .s(s), .v(v)
    );

    always #5 clk = ~clk;

    logic [7:0] vr[7] = '{8'd255, 8'd0,   8'd255, 8'd255, 8'd0,   8'd128, 8'd0};
    logic [7:0] vg[7] = '{8'd0,   8'd255, 8'd0,   8'd128, 8'd64,  8'd128, 8'd0};
    logic [7:0] vb[7] = '{8'd0,   8'd0,   8'd255, 8'd0,   8'd128, 8'd128, 8'd0};
    logic [8:0] eh[7] = '{9'd0,   9'd120, 9'd300, 9'd30,  9'd210, 9'd0,   9'd0};
    logic [7:0] es[7] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0,   8'd0};
    logic [7:0] ev[7] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 8'd0};

    task automatic convert(input logic [7:0] rr, gg, bb, output int lat);
        @(negedge clk);
        r = rr; g = gg; b = bb; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || h !== 9'd0 || s !== 8'd0 || v !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: ov=%b ir=%b h=%0d s=%0d v=%0d, want ov=0 ir=1 h=s=v=0", out_valid, in_ready, h, s, v);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_colours;
        int lat;
        for (int i = 0; i < 7; i++) begin
            convert(vr[i], vg[i], vb[i], lat);
            checks++;
            if (lat !== 35) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d, want 35", i, lat);
            end
            checks++;
            if (h !== eh[i]) begin
                errors++;
                $display("FAIL hue[%0d]: got %0d, want %0d", i, h, eh[i]);
            end
            checks++;
            if (s !== es[i]) begin
                errors++;
                $display("FAIL sat[%0d]: got %0d, want %0d", i, s, es[i]);
            end
            checks++;
            if (v !== ev[i]) begin
                errors++;
                $display("FAIL val[%0d]: got %0d, want %0d", i, v, ev[i]);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL handshake[%0d]: ov=%b ir=%b, want ov=0 ir=1", i, out_valid, in_ready);
            end
            checks++;
            if (h !== eh[i] || s !== es[i] || v !== ev[i]) begin
                errors++;
                $display("FAIL hold_after[%0d]: h=%0d s=%0d v=%0d, want %0d %0d %0d", i, h, s, v, eh[i], es[i], ev[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        convert(8'd255, 8'd128, 8'd0, lat);
        checks++;
        if (lat !== 35 || h !== 9'd30) begin
            errors++;
            $display("FAIL bp_result: lat=%0d h=%0d, want 35 30", lat, h);
        end
        r = 8'd0; g = 8'd0; b = 8'd7; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            r = 8'(c * 20);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || h !== 9'd30 || s !== 8'd255 || v !== 8'd255) begin
                errors++;
                $display("FAIL bp_stable[%0d]: ov=%b ir=%b h=%0d s=%0d v=%0d, want 1 0 30 255 255", c, out_valid, in_ready, h, s, v);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || h !== 9'd30 || v !== 8'd255) begin
            errors++;
            $display("FAIL bp_not_taken: ov=%b ir=%b h=%0d v=%0d, want 0 1 30 255", out_valid, in_ready, h, v);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] cr[3] = '{8'd0,   8'd255, 8'd0};
        logic [7:0] cg[3] = '{8'd255, 8'd0,   8'd64};
        logic [7:0] cb[3] = '{8'd0,   8'd255, 8'd128};
        logic [8:0] ch[3] = '{9'd120, 9'd300, 9'd210};
        int acc[3];
        int n = 0;
        int k = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (k >= 3 || h !== ch[k]) begin
                    errors++;
                    $display("FAIL b2b_hue[%0d]: got %0d, want %0d", k, h, k < 3 ? ch[k] : 9'd511);
                end
                k++;
            end
            if (in_ready && n < 3) begin
                r = cr[n]; g = cg[n]; b = cb[n]; in_valid = 1'b1;
                acc[n] = c;
                n++;
            end else if (n == 3) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        checks++;
        if (n !== 3 || k !== 3) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d results=%0d, want 3 3", n, k);
        end
        checks++;
        if (acc[1] - acc[0] !== 37 || acc[2] - acc[1] !== 37) begin
            errors++;
            $display("FAIL b2b_spacing: %0d %0d, want 37 37", acc[1] - acc[0], acc[2] - acc[1]);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int pulses = 0;
        @(negedge clk);
        r = 8'd255; g = 8'd0; b = 8'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || h !== 9'd0 || s !== 8'd0 || v !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: ov=%b ir=%b h=%0d s=%0d v=%0d, want 0 1 0 0 0", out_valid, in_ready, h, s, v);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL mid_no_pulse: %0d valid cycles, want 0", pulses);
        end
        convert(8'd0, 8'd255, 8'd0, lat);
        checks++;
        if (lat !== 35 || h !== 9'd120 || s !== 8'd255 || v !== 8'd255) begin
            errors++;
            $display("FAIL mid_after: lat=%0d h=%0d s=%0d v=%0d, want 35 120 255 255", lat, h, s, v);
        end
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_colours();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
